mul_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one 64x64 signed radix-2 Booth multiplier among NUM_REQ requesters.
- Accepts one operand pair per grant and drives the multiplier's op_start/op_clear protocol, including the mandatory clear between operations.
- Returns the 128-bit signed product with the requester id. A watchdog aborts hung operations.
- Sits between the core's issue logic and the shared multiplier instance.

---
 rtl/mul_pkg.sv | 14 +
 rtl/mul_arbiter_if.sv | 42 ++++
 rtl/rr_arbiter.sv | 26 ++
 rtl/mul_arbiter.sv | 133 +++++++++++++
 tb/tb_mul_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared constants for the multiplier arbiter slice
package mul_pkg;

    localparam int MUL_W       = 64;
    localparam int PROD_W      = 128;
    localparam int MUL_MAX_LAT = 194;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_CLEAR = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

endpackage

// File: rtl/mul_arbiter_if.sv
// rtl/mul_arbiter_if.sv - request/response and multiplier-side bundle for mul_arbiter
interface mul_arbiter_if
    import mul_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*MUL_W-1:0] req_multiplier;
    logic [NUM_REQ*MUL_W-1:0] req_multiplicand;

    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [PROD_W-1:0]        rsp_result;
    logic                     rsp_err;

    logic                     mul_op_start;
    logic                     mul_op_clear;
    logic [MUL_W-1:0]         mul_multiplier;
    logic [MUL_W-1:0]         mul_multiplicand;
    logic                     mul_op_done;
    logic [PROD_W-1:0]        mul_result;

    // slave: the arbiter; master: issue logic plus the shared multiplier
    modport slave (
        input  req_valid, req_multiplier, req_multiplicand, rsp_ready,
               mul_op_done, mul_result,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err,
               mul_op_start, mul_op_clear, mul_multiplier, mul_multiplicand
    );

    modport master (
        output req_valid, req_multiplier, req_multiplicand, rsp_ready,
               mul_op_done, mul_result,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err,
               mul_op_start, mul_op_clear, mul_multiplier, mul_multiplicand
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant starting at ptr
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [PW-1:0] idx;

    // Walk offsets from farthest to nearest so the requester closest to ptr wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k) % N);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - round-robin sequencer sharing one Booth multiplier among requesters
module mul_arbiter
    import mul_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset_n,
    mul_arbiter_if.slave  bus,
    output logic          busy
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    if (TIMEOUT <= MUL_MAX_LAT) begin : g_bad_timeout
        $error("TIMEOUT must exceed the multiplier worst-case latency");
    end
    if (ID_W != $clog2(NUM_REQ)) begin : g_bad_id_w
        $error("ID_W must equal clog2(NUM_REQ)");
    end

    logic [2:0]         state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    owner;
    logic [WD_W-1:0]    wdog;
    logic [MUL_W-1:0]   op_a;
    logic [MUL_W-1:0]   op_b;
    logic [PROD_W-1:0]  result_q;
    logic               err_q;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic [MUL_W-1:0]   sel_a;
    logic [MUL_W-1:0]   sel_b;
    logic               handshake;
    logic [ID_W-1:0]    rr_next;
    logic               wdog_expired;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (ID_W)
    ) u_rr (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    always_comb begin
        grant_idx = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = ID_W'(i);
                sel_a     = bus.req_multiplier[i*MUL_W +: MUL_W];
                sel_b     = bus.req_multiplicand[i*MUL_W +: MUL_W];
            end
        end
    end

    // Grant is masked while reset is held so no transfer can appear during reset.
    assign bus.req_ready = (state == ST_IDLE && reset_n) ? grant : '0;
    assign handshake     = |(bus.req_valid & bus.req_ready);
    assign rr_next       = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    assign wdog_expired  = (wdog == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            wdog     <= '0;
            op_a     <= '0;
            op_b     <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (handshake) begin
                        op_a   <= sel_a;
                        op_b   <= sel_b;
                        owner  <= grant_idx;
                        rr_ptr <= rr_next;
                        state  <= ST_START;
                    end
                end
                ST_START: begin
                    wdog  <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done arriving on the expiry cycle still counts as a good result.
                    if (bus.mul_op_done) begin
                        result_q <= bus.mul_result;
                        err_q    <= 1'b0;
                        state    <= ST_CLEAR;
                    end else if (wdog_expired) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                        state    <= ST_CLEAR;
                    end else begin
                        wdog <= wdog + WD_W'(1);
                    end
                end
                ST_CLEAR: begin
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy                 = (state != ST_IDLE);
    assign bus.rsp_valid        = (state == ST_RESP);
    assign bus.rsp_id           = owner;
    assign bus.rsp_result       = result_q;
    assign bus.rsp_err          = err_q;
    assign bus.mul_op_start     = (state == ST_START);
    assign bus.mul_op_clear     = (state == ST_CLEAR);
    assign bus.mul_multiplier   = op_a;
    assign bus.mul_multiplicand = op_b;

endmodule

// File: tb/tb_mul_arbiter.sv
// tb/tb_mul_arbiter.sv - scoreboard bench for mul_arbiter with a behavioural multiplier
module tb_mul_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 255;

    typedef struct {
        int           id;
        logic [127:0] res;
        logic         err;
    } exp_t;

    logic clk;
    logic reset_n;
    logic busy;

    mul_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    mul_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .busy    (busy)
    );

    int          checks;
    int          failures;
    exp_t        sb[$];
    int          remaining[NUM_REQ];
    logic [63:0] op_a[NUM_REQ];
    logic [63:0] op_b[NUM_REQ];
    int          lat_cfg;
    bit          hang;
    int          stray_req;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic push(input int id, input logic [127:0] res, input logic err);
        exp_t e;
        e.id  = id;
        e.res = res;
        e.err = err;
        sb.push_back(e);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, 128'(bus.req_ready), 128'd0);
        chk({tag, "_rsp_valid"}, 128'(bus.rsp_valid), 128'd0);
        chk({tag, "_rsp_id"}, 128'(bus.rsp_id), 128'd0);
        chk({tag, "_rsp_result"}, bus.rsp_result, 128'd0);
        chk({tag, "_rsp_err"}, 128'(bus.rsp_err), 128'd0);
        chk({tag, "_busy"}, 128'(busy), 128'd0);
        chk({tag, "_op_start"}, 128'(bus.mul_op_start), 128'd0);
        chk({tag, "_op_clear"}, 128'(bus.mul_op_clear), 128'd0);
        chk({tag, "_mul_a"}, 128'(bus.mul_multiplier), 128'd0);
        chk({tag, "_mul_b"}, 128'(bus.mul_multiplicand), 128'd0);
    endtask

    // Drives req_valid from remaining[]; ends on first rsp_valid or when all work drained.
    task automatic run_ops(input bit stop_at_rsp, input int budget);
        int         n;
        bit         fin;
        logic [3:0] hs;
        n   = 0;
        fin = 0;
        while (!fin && n < budget) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                bus.req_valid[i] = (remaining[i] > 0);
                bus.req_multiplier[i*64 +: 64]   = op_a[i];
                bus.req_multiplicand[i*64 +: 64] = op_b[i];
            end
            @(negedge clk);
            hs = bus.req_valid & bus.req_ready;
            if (stop_at_rsp && bus.rsp_valid) fin = 1;
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) if (hs[i]) remaining[i]--;
            if (!stop_at_rsp) begin
                fin = (sb.size() == 0);
                for (int i = 0; i < NUM_REQ; i++) if (remaining[i] > 0) fin = 0;
            end
            n++;
        end
        if (!fin) begin
            failures++;
            $display("FAIL run_ops_timeout got=%0d cycles exp=<%0d", n, budget);
        end
    endtask

    // Behavioural multiplier: samples operands the cycle after op_start, refuses to start until cleared.
    initial begin
        int           cnt;
        bit           active;
        bit           need_clear;
        int           stray_ack;
        logic signed [127:0] ea;
        logic signed [127:0] eb;
        logic [127:0] prod;
        bus.mul_op_done = 1'b0;
        bus.mul_result  = '0;
        cnt = 0; active = 0; need_clear = 0; stray_ack = 0; prod = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mul_op_done = 1'b0;
            if (!reset_n) begin
                active     = 0;
                need_clear = 0;
            end else begin
                if (bus.mul_op_clear) need_clear = 0;
                if (active) begin
                    if (cnt == lat_cfg) begin
                        ea   = $signed(bus.mul_multiplier);
                        eb   = $signed(bus.mul_multiplicand);
                        prod = ea * eb;
                    end
                    cnt--;
                    if (cnt == 0) begin
                        active          = 0;
                        need_clear      = 1;
                        bus.mul_op_done = 1'b1;
                        bus.mul_result  = prod;
                    end
                end else if (bus.mul_op_start && !need_clear && !hang) begin
                    cnt    = lat_cfg;
                    active = 1;
                end
                if (stray_req != stray_ack) begin
                    stray_ack       = stray_req;
                    bus.mul_op_done = 1'b1;
                    bus.mul_result  = 128'hDEAD_BEEF_0BAD_F00D_1234_5678_9ABC_DEF0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every response handshake.
    initial begin
        int   cyc;
        int   n_start;
        int   n_clear;
        int   start_cyc;
        int   clear_cyc;
        int   done_cyc;
        bit   viol;
        exp_t e;
        cyc = 0; n_start = 0; n_clear = 0; start_cyc = 0; clear_cyc = 0; done_cyc = 0; viol = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                n_start = 0;
                n_clear = 0;
                viol    = 0;
            end else begin
                if (bus.mul_op_start) begin n_start++; start_cyc = cyc; end
                if (bus.mul_op_clear) begin n_clear++; clear_cyc = cyc; end
                if (bus.mul_op_done && n_clear == 0) done_cyc = cyc;
                if ((|bus.req_ready && busy) || (bus.mul_op_start && bus.mul_op_clear)) viol = 1;
                if (bus.rsp_valid && bus.rsp_ready) begin
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_rsp got=id%0d exp=none", bus.rsp_id);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_id", 128'(bus.rsp_id), 128'(e.id));
                        chk("rsp_result", bus.rsp_result, e.res);
                        chk("rsp_err", 128'(bus.rsp_err), 128'(e.err));
                        chk("op_start_count", 128'(n_start), 128'd1);
                        chk("op_clear_count", 128'(n_clear), 128'd1);
                        chk("exclusive_signals", 128'(viol), 128'd0);
                        if (e.err) begin
                            chk("watchdog_latency_ok",
                                128'((clear_cyc - start_cyc) >= TIMEOUT && (clear_cyc - start_cyc) <= TIMEOUT + 2),
                                128'd1);
                        end else begin
                            chk("clear_after_done", 128'(clear_cyc - done_cyc), 128'd1);
                        end
                    end
                    n_start = 0;
                    n_clear = 0;
                    viol    = 0;
                end
            end
        end
    end

    initial begin
        int seen;
        checks = 0; failures = 0;
        hang = 0; stray_req = 0; lat_cfg = 130;
        for (int i = 0; i < NUM_REQ; i++) begin
            remaining[i] = 0; op_a[i] = '0; op_b[i] = '0;
        end
        reset_n              = 1'b0;
        bus.req_valid        = '1;
        bus.req_multiplier   = '1;
        bus.req_multiplicand = '1;
        bus.rsp_ready        = 1'b1;

        #12;
        chk("reset_req_ready_masked", 128'(bus.req_ready), 128'd0);
        bus.req_valid = '0;
        #10;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all_zero("post_reset");

        // Fairness: all four valid, requester 0 wants two ops
        for (int i = 0; i < NUM_REQ; i++) begin
            op_a[i] = 64'(i + 1);
            op_b[i] = 64'd1000;
        end
        remaining[0] = 2; remaining[1] = 1; remaining[2] = 1; remaining[3] = 1;
        push(0, 128'd1000, 1'b0);
        push(1, 128'd2000, 1'b0);
        push(2, 128'd3000, 1'b0);
        push(3, 128'd4000, 1'b0);
        push(0, 128'd1000, 1'b0);
        run_ops(0, 2000);

        // Single request with wrap of the pointer (rr=1, only req0)
        lat_cfg = 160;
        op_a[0] = -64'd3;
        op_b[0] = 64'd5;
        remaining[0] = 1;
        push(0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1, 1'b0);
        run_ops(0, 400);

        // Back-to-back at maximum latency; second op only starts if the clear was issued
        lat_cfg = 194;
        op_a[1] = 64'd7;                     op_b[1] = 64'd9;
        op_a[2] = 64'h7FFF_FFFF_FFFF_FFFF;   op_b[2] = 64'd2;
        remaining[1] = 1; remaining[2] = 1;
        push(1, 128'd63, 1'b0);
        push(2, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFE, 1'b0);
        run_ops(0, 800);

        // Backpressure with stray done, then skip from rr=2 to req3
        lat_cfg = 170;
        op_a[1] = 64'd11;                    op_b[1] = -64'd2;
        op_a[3] = 64'h8000_0000_0000_0000;   op_b[3] = -64'd1;
        remaining[1] = 2;
        bus.rsp_ready = 1'b0;
        push(1, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEA, 1'b0);
        push(3, 128'h0000_0000_0000_0000_8000_0000_0000_0000, 1'b0);
        push(1, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEA, 1'b0);
        run_ops(1, 400);
        remaining[3] = 1;
        bus.req_valid[3] = 1'b1;
        bus.req_multiplier[3*64 +: 64]   = op_a[3];
        bus.req_multiplicand[3*64 +: 64] = op_b[3];
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("stall_rsp_valid", 128'(bus.rsp_valid), 128'd1);
            chk("stall_rsp_id", 128'(bus.rsp_id), 128'd1);
            chk("stall_rsp_result", bus.rsp_result, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEA);
            chk("stall_rsp_err", 128'(bus.rsp_err), 128'd0);
            chk("stall_req_ready", 128'(bus.req_ready), 128'd0);
            if (c == 5) stray_req++;
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        run_ops(0, 800);

        // Watchdog: multiplier never answers
        hang = 1;
        op_a[2] = 64'd5; op_b[2] = 64'd5;
        remaining[2] = 1;
        push(2, 128'd0, 1'b1);
        run_ops(0, 600);
        hang = 0;

        // Reset during WAIT: everything clears at once and no response follows
        lat_cfg = 190;
        op_a[0] = 64'd9; op_b[0] = 64'd4;
        bus.req_multiplier[63:0]   = op_a[0];
        bus.req_multiplicand[63:0] = op_b[0];
        bus.req_valid = 4'b0001;
        seen = 0;
        while (seen < 20 && !(bus.req_ready[0])) begin
            @(negedge clk);
            seen++;
        end
        chk("reset_test_grant", 128'(bus.req_ready[0]), 128'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 4'b0010;
        repeat (50) @(posedge clk);
        #1;
        chk("reset_test_in_wait", 128'(busy), 128'd1);
        reset_n = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        bus.req_valid = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 220; c++) begin
            @(negedge clk);
            if (bus.rsp_valid || busy) seen++;
        end
        chk("no_rsp_after_reset", 128'(seen), 128'd0);
        chk("scoreboard_drained", 128'(sb.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
